// File: rtl/sel_mux_skid.sv
// sel_mux_skid: N-input selector (binary/one-hot, illegal-select flag) feeding a registered 2-entry skid buffer
module sel_mux_skid #(
  parameter int BITS   = 32,
  parameter int NUM_IN = 4,
  parameter bit ONEHOT = 1'b0,
  localparam int SEL_W = ONEHOT ? NUM_IN : $clog2(NUM_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       sel,
  input  logic [NUM_IN*BITS-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        out_data,
  output logic                   out_sel_err
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, nxt;
  logic [BITS:0] entry, main_q, skid_q;
  logic accept, pop;
  always_comb begin
    entry = {1'b1, in_data[BITS-1:0]};
    for (int k = 0; k < NUM_IN; k++)
      if (ONEHOT ? (sel == (SEL_W'(1) << k)) : (sel == SEL_W'(k))) entry = {1'b0, in_data[k*BITS +: BITS]};
  end
  assign accept = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_valid = state != EMPTY;
  assign {out_sel_err, out_data} = main_q;
  always_comb
    nxt = state == EMPTY ? (accept ? ONE : EMPTY) :
          state == TWO   ? (pop ? ONE : TWO) :
          (accept && !pop) ? TWO : (pop && !accept) ? EMPTY : ONE;
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready <= rst_n;
    end else begin
      state <= nxt;
      in_ready <= nxt != TWO;
      if (accept && (state == EMPTY || pop)) main_q <= entry;
      else if (state == TWO && pop) main_q <= skid_q;
      if (state == ONE && accept && !pop) skid_q <= entry;
    end
endmodule

// File: tb/tb_sel_mux_skid.sv
// tb_sel_mux_skid: directed self-checking bench for sel_mux_skid in binary, 3-input and one-hot configurations
module tb_sel_mux_skid;
  logic clk = 1'b0, rst_n, flush, in_valid, out_ready;
  logic [1:0] sel0, sel1;
  logic [3:0] sel2;
  logic [127:0] data0, data2;
  logic [95:0] data1;
  logic rdy0, rdy1, rdy2, v0, v1, v2, e0, e1, e2;
  logic [31:0] d0, d1, d2;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sel_mux_skid #(.BITS(32), .NUM_IN(4), .ONEHOT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .sel(sel0), .in_data(data0), .out_valid(v0),
    .out_ready(out_ready), .out_data(d0), .out_sel_err(e0));
  sel_mux_skid #(.BITS(32), .NUM_IN(3), .ONEHOT(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .sel(sel1), .in_data(data1), .out_valid(v1),
    .out_ready(out_ready), .out_data(d1), .out_sel_err(e1));
  sel_mux_skid #(.BITS(32), .NUM_IN(4), .ONEHOT(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy2), .sel(sel2), .in_data(data2), .out_valid(v2),
    .out_ready(out_ready), .out_data(d2), .out_sel_err(e2));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel0 = '0; sel1 = '0; sel2 = '0;
    data0 = {32'h3333, 32'h2222, 32'h1111, 32'h0000};
    data1 = {32'hA2, 32'hA1, 32'hA0};
    data2 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    step; step;
    chk("rst_valid", v0, 0); chk("rst_data", d0, 0); chk("rst_ready", rdy0, 0); chk("rst_err", e0, 0);
    rst_n = 1'b1;
    step;
    chk("rel_ready", rdy0, 1); chk("rel_valid", v0, 0);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel0 = 2'(i);
      step;
      chk("bin_valid", v0, 1); chk("bin_data", d0, 64'h1111 * i); chk("bin_err", e0, 0); chk("bin_ready", rdy0, 1);
    end
    in_valid = 1'b0;
    step;
    chk("bin_drain", v0, 0);
    out_ready = 1'b0; in_valid = 1'b1; sel0 = 2'd1;
    step;
    chk("stall_a_valid", v0, 1); chk("stall_a_data", d0, 32'h1111); chk("stall_a_ready", rdy0, 1);
    sel0 = 2'd2;
    step;
    chk("stall_b_ready", rdy0, 0); chk("stall_b_data", d0, 32'h1111);
    sel0 = 2'd3;
    step;
    chk("stall_hold_data", d0, 32'h1111); chk("stall_hold_ready", rdy0, 0); chk("stall_hold_valid", v0, 1);
    out_ready = 1'b1;
    step;
    chk("stall_out_b", d0, 32'h2222); chk("stall_out_b_ready", rdy0, 1);
    step;
    chk("stall_out_c", d0, 32'h3333); chk("stall_out_c_valid", v0, 1);
    in_valid = 1'b0;
    step;
    chk("stall_empty", v0, 0);
    in_valid = 1'b1; sel1 = 2'd3; sel2 = 4'b0110;
    step;
    chk("ill3_data", d1, 32'hA0); chk("ill3_err", e1, 1);
    chk("oh_multi_data", d2, 32'hD0); chk("oh_multi_err", e2, 1);
    sel1 = 2'd2; sel2 = 4'b0100;
    step;
    chk("leg3_data", d1, 32'hA2); chk("leg3_err", e1, 0);
    chk("oh_leg_data", d2, 32'hD2); chk("oh_leg_err", e2, 0);
    sel1 = 2'd1; sel2 = 4'b0000;
    step;
    chk("leg3b_data", d1, 32'hA1); chk("leg3b_err", e1, 0);
    chk("oh_zero_data", d2, 32'hD0); chk("oh_zero_err", e2, 1);
    sel2 = 4'b1000;
    step;
    chk("oh_top_data", d2, 32'hD3); chk("oh_top_err", e2, 0);
    in_valid = 1'b0;
    step;
    out_ready = 1'b0; in_valid = 1'b1; sel0 = 2'd0;
    step;
    sel0 = 2'd1;
    step;
    chk("fl_two_ready", rdy0, 0);
    flush = 1'b1; sel0 = 2'd2;
    step;
    chk("fl_valid", v0, 0); chk("fl_ready", rdy0, 1); chk("fl_data", d0, 0); chk("fl_err", e0, 0);
    sel0 = 2'd3;
    step;
    chk("fl_acc_valid", v0, 0); chk("fl_acc_ready", rdy0, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step;
    chk("fl_no_stale", v0, 0);
    in_valid = 1'b1; sel0 = 2'd2;
    step;
    chk("fl_post_data", d0, 32'h2222); chk("fl_post_valid", v0, 1);
    in_valid = 1'b0;
    step;
    chk("fl_post_empty", v0, 0);
    out_ready = 1'b0; in_valid = 1'b1; sel0 = 2'd1;
    step;
    sel0 = 2'd2;
    step;
    chk("rt_two_ready", rdy0, 0);
    out_ready = 1'b1; rst_n = 1'b0; in_valid = 1'b0;
    step;
    chk("rt_valid", v0, 0); chk("rt_data", d0, 0); chk("rt_ready", rdy0, 0);
    rst_n = 1'b1;
    step;
    chk("rt_rel_ready", rdy0, 1); chk("rt_rel_valid", v0, 0);
    step;
    chk("rt_no_stale", v0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
